// File: rtl/spi_byte_streamer.sv
// Byte-stream front end for the spi register-port peripheral: queues bytes in a FIFO and runs one
// TX / CTRL-start / wait / RX / CTRL-stop register sequence per byte, returning each received byte.
module spi_byte_streamer #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [2:0]  CLK_DIV  = 3'b001,
  parameter logic [1:0]  SPI_MODE = 2'b00,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       m_last,
  input  logic       m_ready,
  output logic       spi_enable,
  output logic       spi_write_enable,
  output logic [1:0] spi_address,
  output logic [7:0] spi_write_data,
  input  logic [7:0] spi_read_data,
  input  logic       spi_done_int,
  output logic       busy,
  output logic       timeout_err
);

  localparam int unsigned AW          = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE     = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE     = AW'(1);
  localparam logic [9:0]    TIMEOUT_CNT = 10'(TIMEOUT);
  localparam logic [9:0]    WAIT_ONE    = 10'd1;

  // CTRL = {enable, master(0), start, clk_div, cpol/cpha}
  localparam logic [7:0] CTRL_START = {1'b1, 1'b0, 1'b1, CLK_DIV, SPI_MODE};
  localparam logic [7:0] CTRL_STOP  = {1'b1, 1'b0, 1'b0, CLK_DIV, SPI_MODE};

  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_TX   = 2'd1;
  localparam logic [1:0] ADDR_RX   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_TX,
    S_WR_START,
    S_WAIT_DONE,
    S_RD_RX,
    S_RD_CAP,
    S_WR_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [8:0]    fifo_mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_last_q, tx_last_d;
  logic          captured_q, captured_d;
  logic [9:0]    wait_cnt_q, wait_cnt_d;
  logic          timeout_err_q, timeout_err_d;
  logic          m_valid_q, m_valid_d;
  logic [7:0]    m_data_q, m_data_d;
  logic          m_last_q, m_last_d;
  logic          spi_en_q, spi_en_d;
  logic          spi_we_q, spi_we_d;
  logic [1:0]    spi_addr_q, spi_addr_d;
  logic [7:0]    spi_wdata_q, spi_wdata_d;
  logic          busy_q, busy_d;
  logic          push;
  logic          pop;

  assign s_ready = (count_q != FULL_CNT);

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    tx_byte_d     = tx_byte_q;
    tx_last_d     = tx_last_q;
    captured_d    = captured_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    m_valid_d     = m_valid_q;
    m_data_d      = m_data_q;
    m_last_d      = m_last_q;
    spi_en_d      = 1'b0;
    spi_we_d      = 1'b0;
    spi_addr_d    = spi_addr_q;
    spi_wdata_d   = spi_wdata_q;
    push          = s_valid && s_ready;
    pop           = 1'b0;

    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    // Core-port outputs are registered, so each branch programs the access of the state it enters.
    unique case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && !m_valid_q) begin
          pop                    = 1'b1;
          {tx_last_d, tx_byte_d} = fifo_mem_q[rd_ptr_q];
          state_d                = S_WR_TX;
          spi_en_d               = 1'b1;
          spi_we_d               = 1'b1;
          spi_addr_d             = ADDR_TX;
          spi_wdata_d            = fifo_mem_q[rd_ptr_q][7:0];
        end
      end
      S_WR_TX: begin
        state_d     = S_WR_START;
        captured_d  = 1'b0;
        spi_en_d    = 1'b1;
        spi_we_d    = 1'b1;
        spi_addr_d  = ADDR_CTRL;
        spi_wdata_d = CTRL_START;
      end
      S_WR_START: begin
        state_d    = S_WAIT_DONE;
        wait_cnt_d = '0;
      end
      S_WAIT_DONE: begin
        wait_cnt_d = wait_cnt_q + WAIT_ONE;
        // First cycle may still see the flag from before the start write took effect.
        if ((wait_cnt_q != '0) && spi_done_int) begin
          state_d    = S_RD_RX;
          spi_en_d   = 1'b1;
          spi_addr_d = ADDR_RX;
        end else if (wait_cnt_d == TIMEOUT_CNT) begin
          timeout_err_d = 1'b1;
          state_d       = S_WR_STOP;
          spi_en_d      = 1'b1;
          spi_we_d      = 1'b1;
          spi_addr_d    = ADDR_CTRL;
          spi_wdata_d   = CTRL_STOP;
        end
      end
      S_RD_RX: begin
        state_d = S_RD_CAP;
      end
      S_RD_CAP: begin
        m_data_d    = spi_read_data;
        m_last_d    = tx_last_q;
        captured_d  = 1'b1;
        state_d     = S_WR_STOP;
        spi_en_d    = 1'b1;
        spi_we_d    = 1'b1;
        spi_addr_d  = ADDR_CTRL;
        spi_wdata_d = CTRL_STOP;
      end
      S_WR_STOP: begin
        if (captured_q) m_valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: FIFO storage has no reset; entries are only read once count_q says they were written.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {s_last, s_data};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      tx_byte_q     <= '0;
      tx_last_q     <= 1'b0;
      captured_q    <= 1'b0;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_last_q      <= 1'b0;
      spi_en_q      <= 1'b0;
      spi_we_q      <= 1'b0;
      spi_addr_q    <= '0;
      spi_wdata_q   <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      tx_byte_q     <= tx_byte_d;
      tx_last_q     <= tx_last_d;
      captured_q    <= captured_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      m_last_q      <= m_last_d;
      spi_en_q      <= spi_en_d;
      spi_we_q      <= spi_we_d;
      spi_addr_q    <= spi_addr_d;
      spi_wdata_q   <= spi_wdata_d;
      busy_q        <= busy_d;
    end
  end

  assign m_valid          = m_valid_q;
  assign m_data           = m_data_q;
  assign m_last           = m_last_q;
  assign spi_enable       = spi_en_q;
  assign spi_write_enable = spi_we_q;
  assign spi_address      = spi_addr_q;
  assign spi_write_data   = spi_wdata_q;
  assign busy             = busy_q;
  assign timeout_err      = timeout_err_q;

endmodule

// File: tb/tb_spi_byte_streamer.sv
// Directed bench for spi_byte_streamer with a small behavioural model of the spi core whose slave
// returns tx ^ rx_key, so every expected received byte is a hand-computable constant.
module tb_spi_byte_streamer;

  localparam int XFER_CYCLES = 16;

  typedef struct packed {
    logic [1:0]  addr;
    logic [7:0]  data;
    logic [31:0] cyc;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_ready = 1'b0;
  logic       spi_enable;
  logic       spi_write_enable;
  logic [1:0] spi_address;
  logic [7:0] spi_write_data;
  logic [7:0] spi_read_data = 8'h00;
  logic       spi_done_int;
  logic       busy;
  logic       timeout_err;

  spi_byte_streamer #(
    .DEPTH(8), .CLK_DIV(3'b001), .SPI_MODE(2'b00), .TIMEOUT(1023)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .spi_enable(spi_enable), .spi_write_enable(spi_write_enable),
    .spi_address(spi_address), .spi_write_data(spi_write_data),
    .spi_read_data(spi_read_data), .spi_done_int(spi_done_int),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  wr_t        wr_log[$];
  logic [8:0] out_q[$];
  int         wrtx_while_valid = 0;
  int         early_reads      = 0;

  logic [7:0] rx_key    = 8'h00;
  logic       core_hang = 1'b0;
  logic       stale_arm = 1'b0;
  logic [7:0] core_tx   = 8'h00;
  logic [7:0] core_rx   = 8'h00;
  logic       core_done = 1'b0;
  int         xfer_cnt  = 0;
  int         stale_cnt = 0;

  logic saw_full   = 1'b0;
  int   accept_cyc = 0;

  assign spi_done_int = core_done || (stale_cnt != 0);

  // Core model: register writes, a fixed-length transfer after a start write, registered RX read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      core_done <= 1'b0;
      xfer_cnt  <= 0;
      stale_cnt <= 0;
    end else begin
      if (stale_cnt != 0) stale_cnt <= stale_cnt - 1;
      if (xfer_cnt > 1) xfer_cnt <= xfer_cnt - 1;
      else if (xfer_cnt == 1) begin
        xfer_cnt <= 0;
        core_rx  <= core_tx ^ rx_key;
        if (!core_hang) core_done <= 1'b1;
      end
      if (spi_enable && !spi_write_enable && spi_address == 2'd2) begin
        spi_read_data <= core_rx;
        if (xfer_cnt != 0) early_reads <= early_reads + 1;
      end
      if (spi_enable && spi_write_enable) begin
        if (spi_address == 2'd1) begin
          core_tx <= spi_write_data;
          if (stale_arm) stale_cnt <= 2;
        end
        if (spi_address == 2'd0) begin
          core_done <= 1'b0;
          if (spi_write_data[5]) xfer_cnt <= XFER_CYCLES;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (spi_enable && spi_write_enable) wr_log.push_back({spi_address, spi_write_data, 32'(cyc)});
      if (m_valid && m_ready) out_q.push_back({m_last, m_data});
      if (m_valid && spi_enable && spi_write_enable && spi_address == 2'd1)
        wrtx_while_valid <= wrtx_while_valid + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [8:0] out_at(input int i);
    if (i < out_q.size()) return out_q[i];
    return 'x;
  endfunction

  function automatic wr_t wr_at(input int i);
    if (i < wr_log.size()) return wr_log[i];
    return 'x;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    int waited;
    waited  = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    @(negedge clk);
    while (!s_ready && waited < 3000) begin
      saw_full = 1'b1;
      waited++;
      @(negedge clk);
    end
    if (!s_ready) check("push_accept", s_ready, 1'b1);
    accept_cyc = cyc;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_outputs(input string tag, input int n, input int budget);
    int c;
    c = 0;
    while (out_q.size() < n && c < budget) begin
      tick(1);
      c++;
    end
    check(tag, out_q.size(), n);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int c;
    c = 0;
    while ((busy || m_valid) && c < budget) begin
      tick(1);
      c++;
    end
    check(tag, busy, 1'b0);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_s_ready"}, s_ready, 1'b1);
    check({pfx, "_m_valid"}, m_valid, 1'b0);
    check({pfx, "_m_data"}, m_data, 8'h00);
    check({pfx, "_m_last"}, m_last, 1'b0);
    check({pfx, "_spi_enable"}, spi_enable, 1'b0);
    check({pfx, "_spi_we"}, spi_write_enable, 1'b0);
    check({pfx, "_spi_addr"}, spi_address, 2'd0);
    check({pfx, "_spi_wdata"}, spi_write_data, 8'h00);
    check({pfx, "_busy"}, busy, 1'b0);
    check({pfx, "_timeout_err"}, timeout_err, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected finish");
    $fatal(1);
  end

  initial begin
    wr_t        e;
    wr_t        e1;
    wr_t        e2;
    logic [7:0] held;
    int         changes;
    int         base;
    int         c;
    logic [8:0] burst_exp [10];

    burst_exp = '{9'h0FF, 9'h0FE, 9'h0FD, 9'h0FC, 9'h0FB,
                  9'h0FA, 9'h0F9, 9'h0F8, 9'h0F7, 9'h1F6};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #1;

    // Single byte: 0xFA out, slave answers 0xFA ^ 0x57 = 0xAD.
    rx_key  = 8'h57;
    m_ready = 1'b1;
    wr_log.delete();
    out_q.delete();
    push(8'hFA, 1'b1);
    wait_outputs("single_out_count", 1, 200);
    wait_idle("single_idle", 50);
    check("single_one_beat", out_q.size(), 1);
    check("single_log_len", wr_log.size(), 3);
    e = wr_at(0);
    check("single_tx_write", {e.addr, e.data}, {2'd1, 8'hFA});
    check("single_wr_tx_latency", e.cyc - accept_cyc, 2);
    e = wr_at(1);
    check("single_start_write", {e.addr, e.data}, {2'd0, 8'hA4});
    e = wr_at(2);
    check("single_stop_write", {e.addr, e.data}, {2'd0, 8'h84});
    check("single_out", out_at(0), 9'h1AD);

    // Burst of DEPTH+2: outputs are ~byte, last only on the final one.
    rx_key   = 8'hFF;
    saw_full = 1'b0;
    out_q.delete();
    for (int i = 0; i < 10; i++) push(8'(i), (i == 9));
    check("burst_s_ready_low", saw_full, 1'b1);
    wait_outputs("burst_out_count", 10, 2000);
    for (int i = 0; i < 10; i++) check($sformatf("burst_out_%0d", i), out_at(i), burst_exp[i]);
    wait_idle("burst_idle", 50);

    // Backpressure: first output held for 200 cycles, nothing else may start.
    rx_key  = 8'h0F;
    m_ready = 1'b0;
    out_q.delete();
    base = wrtx_while_valid;
    push(8'h30, 1'b0);
    push(8'h31, 1'b0);
    push(8'h32, 1'b1);
    c = 0;
    while (!m_valid && c < 300) begin
      tick(1);
      c++;
    end
    check("bp_valid_seen", m_valid, 1'b1);
    held = m_data;
    check("bp_first_data", held, 8'h3F);
    changes = 0;
    repeat (200) begin
      @(negedge clk);
      if (m_data !== held || m_valid !== 1'b1) changes++;
    end
    @(posedge clk);
    #1;
    check("bp_output_stable", changes, 0);
    check("bp_no_wr_tx_while_valid", wrtx_while_valid - base, 0);
    m_ready = 1'b1;
    wait_outputs("bp_out_count", 3, 500);
    check("bp_out_0", out_at(0), 9'h03F);
    check("bp_out_1", out_at(1), 9'h03E);
    check("bp_out_2", out_at(2), 9'h13D);
    wait_idle("bp_idle", 50);

    // Timeout: done never rises, byte is dropped after 1023 wait cycles.
    core_hang = 1'b1;
    wr_log.delete();
    out_q.delete();
    push(8'h55, 1'b1);
    c = 0;
    while (!timeout_err && c < 1500) begin
      tick(1);
      c++;
    end
    check("to_err_set", timeout_err, 1'b1);
    wait_idle("to_idle", 50);
    check("to_log_len", wr_log.size(), 3);
    e1 = wr_at(1);
    e2 = wr_at(2);
    check("to_stop_write", {e2.addr, e2.data}, {2'd0, 8'h84});
    check("to_wait_cycles", e2.cyc - e1.cyc - 1, 1023);
    check("to_no_output", out_q.size(), 0);
    core_hang = 1'b0;
    push(8'h66, 1'b1);
    wait_outputs("to_next_count", 1, 200);
    check("to_next_out", out_at(0), 9'h169);
    check("to_err_sticky", timeout_err, 1'b1);
    wait_idle("to_next_idle", 50);

    // Stale done during WR_START and the first wait cycle must be ignored.
    rx_key    = 8'hA5;
    stale_arm = 1'b1;
    out_q.delete();
    base = early_reads;
    push(8'h11, 1'b1);
    wait_outputs("stale_out_count", 1, 200);
    wait_idle("stale_idle", 50);
    stale_arm = 1'b0;
    check("stale_one_beat", out_q.size(), 1);
    check("stale_out", out_at(0), 9'h1B4);
    check("stale_no_early_read", early_reads - base, 0);

    // Reset while waiting for done with three bytes still queued.
    core_hang = 1'b1;
    wr_log.delete();
    push(8'h70, 1'b0);
    push(8'h71, 1'b0);
    push(8'h72, 1'b0);
    push(8'h73, 1'b1);
    c = 0;
    while (wr_log.size() < 2 && c < 100) begin
      tick(1);
      c++;
    end
    tick(20);
    check("rst_pre_busy", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    @(posedge clk);
    #1;
    core_hang = 1'b0;
    wr_log.delete();
    out_q.delete();
    tick(100);
    check("midrst_no_core_writes", wr_log.size(), 0);
    check("midrst_no_output", out_q.size(), 0);
    check("midrst_fifo_empty", s_ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_byte_streamer.md
# spi_byte_streamer

Front-end sequencer that sits directly upstream of the `spi` peripheral and drives its 2-bit-address register port. It accepts a byte stream over valid/ready, buffers it in a FIFO, and runs one full-duplex SPI master transfer per byte by programming CTRL and TX, waiting for `done_int`, and reading RX. Each received byte is emitted on an output valid/ready stream, so software or a DMA can push frames without touching SPI registers.

## Interface
- `DEPTH`, 8: TX FIFO entries; power of two, ≥2.
- `CLK_DIV`, 3'b001: value written to CTRL[4:2] (core sclk divider).
- `SPI_MODE`, 2'b00: value written to CTRL[1:0] (CPOL/CPHA).
- `TIMEOUT`, 1023: max cycles spent in WAIT_DONE before abort; 10-bit counter.

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  input byte valid.
- `s_data`  in  8  byte to transmit.
- `s_last`  in  1  marks final byte of a frame; carried to `m_last`.
- `s_ready`  out  1  FIFO not full.
- `m_valid`  out  1  received byte valid.
- `m_data`  out  8  received byte.
- `m_last`  out  1  copy of `s_last` of the transmitted byte.
- `m_ready`  in  1  downstream accepts.
- `spi_enable`  out  1  to core `enable`.
- `spi_write_enable`  out  1  to core `write_enable`.
- `spi_address`  out  2  to core `address`: 0 CTRL, 1 TX, 2 RX.
- `spi_write_data`  out  8  to core `write_data`.
- `spi_read_data`  in  8  from core `read_data`; valid one cycle after address presented.
- `spi_done_int`  in  1  core transfer-complete flag; cleared by a CTRL write with start=0.
- `busy`  out  1  FSM not in IDLE.
- `timeout_err`  out  1  sticky; set on any WAIT_DONE timeout, cleared only by `rst`.

## Operation
- CTRL byte = {1'b1 enable, 1'b0 master, start, CLK_DIV, SPI_MODE}. Start byte 8'b1_0_1_ddd_mm; stop byte 8'b1_0_0_ddd_mm.
- FIFO: 9-bit entries {last, data}; push on `s_valid && s_ready`; pop only in IDLE→WR_TX. Pointers wrap modulo DEPTH; full/empty from (log2(DEPTH)+1)-bit count.
- FSM, one register access per state, `spi_enable`=1 only in write/read states:
  - IDLE: if FIFO non-empty and `m_valid`=0 → pop, latch {last,data} → WR_TX.
  - WR_TX: addr 1, we=1, data=byte → WR_START.
  - WR_START: addr 0, we=1, start byte → WAIT_DONE; counter cleared.
  - WAIT_DONE: `spi_done_int` ignored on the first cycle (stale flag); thereafter high → RD_RX. Counter reaching TIMEOUT → set `timeout_err`, discard byte → WR_STOP with no output.
  - RD_RX: addr 2, we=0 → RD_CAP.
  - RD_CAP: capture `spi_read_data` into `m_data`, latched last into `m_last` → WR_STOP.
  - WR_STOP: addr 0, we=1, stop byte; if a byte was captured set `m_valid` → IDLE.
- Output register single-entry: `m_valid` held until `m_valid && m_ready`. IDLE will not start a new byte while `m_valid`=1 (backpressure stalls SPI, never drops data).
- Byte order preserved; one output per non-aborted input.

## Timing
- Reset (sync, takes effect on the edge it is sampled): FIFO empty, state IDLE, `s_ready`=1, `m_valid`=0, `m_data`=0, `m_last`=0, `spi_enable`=0, `spi_write_enable`=0, `spi_address`=0, `spi_write_data`=0, `busy`=0, `timeout_err`=0. Reset mid-transfer abandons the transfer without a stop write; FIFO contents lost.
- Input accepted at edge N → WR_TX on core port at cycle N+2 (FIFO write, then IDLE pop) if FSM idle and `m_valid`=0.
- Overhead per byte excluding wait: 6 cycles (WR_TX, WR_START, RD_RX, RD_CAP, WR_STOP, IDLE).
- `m_valid` rises the cycle after WR_STOP; with `m_ready`=1 held it drops one cycle later.
- Simultaneous push and pop: both occur, count unchanged. Push while full: blocked by `s_ready`=0.
- `spi_done_int` high during WR_*/RD_* states has no effect.

## Test plan
- Single byte: push 0xFA (last=1) with a looped-back core slave sending 0xAD → core sees TX write 0xFA, start byte 0xA4 (CLK_DIV=1, mode 0), stop byte 0x84; `m_data`=0xAD, `m_last`=1, exactly one `m_valid` beat.
- Burst of DEPTH+2 bytes 0x00..0x09 with `m_ready`=1 → `s_ready` drops after 8 pending, all 10 outputs in order, last flag only on 0x09.
- Backpressure: `m_ready`=0 for 200 cycles after first output → no WR_TX issued while `m_valid`=1; `m_data` stable; resume yields remaining bytes intact.
- Timeout: core `spi_done_int` held 0 → after 1023 WAIT_DONE cycles `timeout_err`=1, stop byte written, no `m_valid`; next byte processes normally, `timeout_err` stays 1.
- Stale done: `spi_done_int` forced high at WR_START → ignored first WAIT_DONE cycle; normal completion still produces exactly one output.
- Reset mid-WAIT_DONE with 3 bytes queued → next cycle all outputs at reset values, FIFO empty, `busy`=0.
